mnist_pixel_streamer: RTL and testbench

MNIST_PIXEL_STREAMER -- requirements
Module: mnist_pixel_streamer

---
 rtl/mnist_pixel_streamer.sv | 151 +++++++++++++++
 tb/tb_mnist_pixel_streamer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mnist_pixel_streamer.sv
// Streams a 784-pixel MNIST image from an internal buffer as one burst with no gaps.
// Define MNIST_STREAMER_DBUF_EN for two ping-pong banks, so the host can write one image while the other streams.
module mnist_pixel_streamer (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       inp_rdy,
    output logic [9:0] pix_count,
    output logic [7:0] pixel,
    output logic       done,
    output logic       wr_err
);
    localparam int unsigned NUM_PIX  = 784;
    localparam logic [9:0]  LAST_PIX = 10'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       busy_q, busy_d;
    logic       inp_rdy_q, inp_rdy_d;
    logic       done_q, done_d;
    logic       wr_err_q, wr_err_d;
    logic [9:0] pix_count_q, pix_count_d;
    logic [9:0] rd_addr;
    logic [7:0] rd_data_q;
    logic       start_ok;
    logic       wr_ok;

    assign start_ok = (state_q == IDLE) && start;

    // The read address runs one pixel ahead of pix_count, which hides the buffer's read latency.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        inp_rdy_d   = 1'b0;
        done_d      = 1'b0;
        pix_count_d = pix_count_q;
        rd_addr     = 10'd0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d     = PREFETCH;
                    busy_d      = 1'b1;
                    pix_count_d = 10'd0;
                end
            end
            PREFETCH: begin
                state_d     = STREAM;
                inp_rdy_d   = 1'b1;
                pix_count_d = 10'd0;
            end
            STREAM: begin
                if (pix_count_q == LAST_PIX) begin
                    state_d     = GAP;
                    done_d      = 1'b1;
                    pix_count_d = 10'd0;
                end else begin
                    inp_rdy_d   = 1'b1;
                    pix_count_d = pix_count_q + 10'd1;
                    rd_addr     = pix_count_q + 10'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_err_d = wr_en && !wr_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            inp_rdy_q   <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            pix_count_q <= 10'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            inp_rdy_q   <= inp_rdy_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
            pix_count_q <= pix_count_d;
        end
    end

`ifdef MNIST_STREAMER_DBUF_EN
    logic fill_q, fill_d;
    logic strm_q, strm_d;
    logic [7:0] mem [2][NUM_PIX];

    assign wr_ok = wr_en && (wr_addr <= LAST_PIX);

    always_comb begin
        fill_d = fill_q;
        strm_d = strm_q;
        if (start_ok) begin
            strm_d = fill_q;
            fill_d = ~fill_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= 1'b0;
            strm_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            strm_q <= strm_d;
        end
    end

    // NOTE: the pixel buffer has no reset so it maps onto block RAM; its contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[fill_q][wr_addr] <= wr_data;
        rd_data_q <= mem[strm_q][rd_addr];
    end
`else
    logic [7:0] mem [NUM_PIX];

    assign wr_ok = wr_en && (wr_addr <= LAST_PIX) && !busy_q;

    // NOTE: the pixel buffer has no reset so it maps onto block RAM; its contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end
`endif

    assign busy      = busy_q;
    assign inp_rdy   = inp_rdy_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign pix_count = pix_count_q;
    assign pixel     = inp_rdy_q ? rd_data_q : 8'd0;

endmodule

// File: tb/tb_mnist_pixel_streamer.sv
// Self-checking bench for mnist_pixel_streamer; expected stream contents go through a scoreboard queue.
// It runs in both configurations, with or without MNIST_STREAMER_DBUF_EN.
module tb_mnist_pixel_streamer;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       inp_rdy;
    logic [9:0] pix_count;
    logic [7:0] pixel;
    logic       done;
    logic       wr_err;

`ifdef MNIST_STREAMER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mdl [2][784];
    int          fill = 0;
    logic [17:0] exp_q [$];

    mnist_pixel_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .inp_rdy   (inp_rdy),
        .pix_count (pix_count),
        .pixel     (pixel),
        .done      (done),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_val(input int k, input int mult, input int add);
        return 8'((k * mult + add) & 255);
    endfunction

    task automatic load_image(input int mult, input int add);
        for (int k = 0; k < 784; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 10'(k);
            wr_data = img_val(k, mult, add);
            mdl[fill][k] = img_val(k, mult, add);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("load_wr_err", wr_err, 0);
    endtask

    task automatic write_px(input logic [9:0] addr, input logic [7:0] data, input bit exp_err);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_err_pulse", wr_err, exp_err);
        @(negedge clk);
        check("wr_err_clear", wr_err, 0);
    endtask

    // Writes a whole image into the fill bank while the other bank is streaming.
    task automatic bg_writer(input int mult, input int add);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 784; k++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(k);
            wr_data = img_val(k, mult, add);
            mdl[fill][k] = img_val(k, mult, add);
            @(negedge clk);
            check("bg_wr_err", wr_err, 0);
        end
        wr_en = 1'b0;
    endtask

    // Negedge n counts from the edge that samples start: n=1..784 carry pixels, done at 785, busy low at 786.
    task automatic run_stream(input int restart_n, input bit gap_start, input int wr_n,
                              input logic [9:0] waddr, input logic [7:0] wdata);
        int          sb;
        bit          exp_err;
        bit          rdy_exp;
        logic [17:0] e;
        sb = DBUF ? fill : 0;
        if (DBUF) fill = fill ^ 1;
        for (int k = 0; k < 784; k++) exp_q.push_back({10'(k), mdl[sb][k]});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_err = 1'b0;
        for (int n = 0; n <= 786; n++) begin
            if (n > 0) @(negedge clk);
            rdy_exp = (n >= 1) && (n <= 784);
            check("inp_rdy", inp_rdy, rdy_exp);
            check("busy", busy, n <= 785);
            check("done", done, n == 785);
            check("wr_err", wr_err, exp_err);
            if (rdy_exp) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {pix_count, pixel}, e);
                end
            end else begin
                check("idle_out", {pix_count, pixel}, 0);
            end
            exp_err = 1'b0;
            start   = (n == restart_n) || (gap_start && n == 785);
            if (n == wr_n) begin
                wr_en   = 1'b1;
                wr_addr = waddr;
                wr_data = wdata;
                exp_err = DBUF ? (waddr > 10'd783) : 1'b1;
                if (DBUF && waddr <= 10'd783) mdl[fill][waddr] = wdata;
            end else if (wr_n >= 0) begin
                wr_en = 1'b0;
            end
        end
        start = 1'b0;
        check("sb_empty", exp_q.size(), 0);
        repeat (8) begin
            @(negedge clk);
            check("quiet_rdy", inp_rdy, 0);
            check("quiet_busy", busy, 0);
        end
    endtask

    initial begin
        int cnt;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 10'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_inp_rdy", inp_rdy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_pix", {pix_count, pixel}, 0);
        #1 reset = 1'b0;

        // Basic burst with buffer[k] = k mod 256.
        load_image(1, 0);
        run_stream(-1, 1'b0, -1, 10'd0, 8'd0);

        // Out-of-range write must be dropped without touching any pixel.
        load_image(7, 3);
        write_px(10'd784, 8'h55, 1'b1);
        write_px(10'd1023, 8'h55, 1'b1);
        run_stream(-1, 1'b0, -1, 10'd0, 8'd0);

        // Starts during STREAM and in GAP must be ignored.
        load_image(13, 91);
        run_stream(101, 1'b1, -1, 10'd0, 8'd0);

        if (DBUF) begin
            load_image(5, 17);
            fork
                run_stream(-1, 1'b0, -1, 10'd0, 8'd0);
                bg_writer(11, 200);
            join
            run_stream(-1, 1'b0, -1, 10'd0, 8'd0);
        end else begin
            load_image(5, 17);
            run_stream(-1, 1'b0, 300, 10'd10, 8'hAA);
        end

        // Reset in the middle of a burst, then restart from pixel 0 with the retained buffer.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (pix_count != 10'd400 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_400", pix_count, 400);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_inp_rdy", inp_rdy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pix", {pix_count, pixel}, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        fill = 0;
        run_stream(-1, 1'b0, -1, 10'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
